serial_rx_cfg: RTL and testbench
================================

// Module: serial_rx_cfg
// PURPOSE
//  Parametrised async serial receiver: next-generation serial_rx with configurable frame format
//  (5-9 data bits, none/odd/even parity, 1-2 stop bits) and per-word error flags. Adds a
//  ready/valid output buffer with overrun detection. Sits between the pad (via internal
//  synchroniser) and a consumer (FIFO / uFork I/O device); pairs with serial_tx in loopback benches.
// PARAMETERS
//  CLK_FREQ   500_000  clock frequency (Hz)
//  BAUD_RATE  115_200  bit rate (bits/s); DIV = CLK_FREQ/BAUD_RATE (truncated), DIV >= 4 required
//  DATA_BITS  8        data bits per frame, 5..9, LSB first
//  PARITY     0        0 = none, 1 = odd, 2 = even
//  STOP_BITS  1        1 or 2
// PORTS
//  i_clk         in   1          system clock, all state on rising edge
//  i_rst_n       in   1          asynchronous active-low reset
//  i_rx          in   1          serial line (idle high), asynchronous to i_clk
//  o_valid       out  1          o_data/flags hold a received word
//  i_ready       in   1          consumer accepts word when o_valid && i_ready
//  o_data        out  DATA_BITS  received word
//  o_parity_err  out  1          word's parity bit mismatched (0 when PARITY==0)
//  o_frame_err   out  1          a stop bit sampled low
//  o_break       out  1          data, parity and first stop bit all sampled low
//  o_overrun     out  1          one-cycle pulse: completed word dropped because buffer full
// BEHAVIOUR
//  Reset: o_valid=0, o_data=0, all flags 0, o_overrun=0, FSM IDLE, synchroniser flops = 1.
//  i_rx passes 2-flop synchroniser (rxs); all references to "line" below mean rxs.
//  Baud counter cnt: loaded on state entry, decrements each clock, "tick" when cnt==0.
//  States:
//   IDLE:   line==0 -> cnt=DIV/2-1, START.
//   START:  tick: line==1 -> IDLE (glitch, no output); else cnt=DIV-1, bitn=0, DATA.
//   DATA:   tick: shift line into MSB of DATA_BITS shift reg (LSB-first), bitn++, cnt=DIV-1;
//           after DATA_BITS samples -> PARITY if PARITY!=0 else STOP.
//   PARITY: tick: perr = (XOR(data)^line) != (PARITY==1); cnt=DIV-1, STOP.
//   STOP:   tick: sample each stop bit; any 0 sets ferr; first stop 0 with data==0 and parity
//           bit 0 (or none) sets brk; after STOP_BITS samples -> DELIVER logic, then
//           IDLE if last stop sample==1, else WAIT_HI.
//   WAIT_HI: stay until line==1, then IDLE (no re-arm during break / stuck-low line).
//  Deliver (same edge as last stop sample, so o_valid rises 1 clk after that sample):
//   buffer empty or being drained this cycle (o_valid&&i_ready) -> load o_data/flags, o_valid=1.
//   buffer full and not drained -> keep old word/flags, pulse o_overrun for exactly 1 cycle.
//  Handshake: o_valid&&i_ready clears o_valid next edge unless a word delivers same edge.
//   o_data/flags stable while o_valid && !i_ready.
//  Latency: start edge on i_rx -> o_valid = 2 (sync) + DIV/2 + (DATA_BITS+P+STOP_BITS)*DIV + 1 clks.
//  Flags are per word, replaced on each delivery; cleared only by reset.
//  Reset mid-frame: FSM to IDLE immediately; partial word discarded, nothing delivered.
//  i_ready ignored while o_valid==0.
// TESTING (CLK_FREQ=500_000, BAUD_RATE=115_200 -> DIV=4; serial_tx drives i_rx unless noted)
//  8N1 send "K" (0x4B), i_ready=1 -> one o_valid pulse, o_data=0x4B, all flags 0, latency per formula.
//  8E1 send 0x4B with parity bit forced wrong -> o_data=0x4B, o_parity_err=1; correct parity -> 0.
//  i_rx low for 1 clk then high -> no o_valid, FSM back in IDLE; next good frame received intact.
//  8N1 hold i_rx low 20 bit times -> o_data=0x00, o_frame_err=1, o_break=1; no second word
//   until line returns high, then 0x55 frame received normally.
//  i_ready=0, send 0x41 then 0x42 -> o_data stays 0x41, o_overrun pulses 1 clk at second frame end;
//   raise i_ready -> o_valid drops next edge.
//  Assert i_rst_n=0 mid-data-bit, release, send 0x5A (7O2 config) -> only 0x5A delivered, flags 0.

Source files
------------

// File: rtl/serial_rx_cfg.sv
// serial_rx_cfg: asynchronous serial receiver with a configurable frame format
// (5-9 data bits, none/odd/even parity, 1-2 stop bits), per-word error flags
// and a single-entry ready/valid output buffer with overrun reporting.
module serial_rx_cfg #(
    parameter int CLK_FREQ  = 500_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);
    localparam int   DIV = CLK_FREQ / BAUD_RATE;
    localparam int   CW  = $clog2(DIV);
    localparam int   BW  = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI} state_t;

    state_t               state, state_nx;
    logic                 s1, rxs;
    logic [CW-1:0]        cnt, cnt_val;
    logic                 cnt_ld, tick;
    logic [BW-1:0]        bitn;
    logic                 stopn;
    logic [DATA_BITS-1:0] sh;
    logic                 pbit, perr, ferr, brk;
    logic                 last_bit, last_stop, deliver;
    logic                 ferr_w, brk_w;

    assign tick      = (cnt == '0);
    assign last_bit  = (bitn == BW'(DATA_BITS - 1));
    assign last_stop = (stopn == 1'(STOP_BITS - 1));
    assign deliver   = (state == S_STOP) && tick && last_stop;
    // The final stop sample lands on the delivery edge, so fold it in here.
    assign ferr_w    = ferr | ~rxs;
    assign brk_w     = brk | (!stopn && !rxs && (sh == '0) && !pbit);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= i_rx;
            rxs <= s1;
        end
    end

    // State register and baud counter (reloaded on state entry, else counts down to 0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (cnt_ld)      cnt <= cnt_val;
            else if (!tick)  cnt <= cnt - 1'b1;
        end
    end

    // Next-state logic; a counter reload accompanies every sampling tick.
    always_comb begin
        state_nx = state;
        cnt_ld   = 1'b0;
        cnt_val  = CW'(DIV - 1);
        case (state)
            S_IDLE: if (!rxs) begin
                state_nx = S_START;
                cnt_ld   = 1'b1;
                cnt_val  = CW'(DIV / 2 - 1);
            end
            S_START: if (tick) begin
                if (rxs) state_nx = S_IDLE;
                else begin
                    state_nx = S_DATA;
                    cnt_ld   = 1'b1;
                end
            end
            S_DATA: if (tick) begin
                cnt_ld = 1'b1;
                if (last_bit) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tick) begin
                cnt_ld   = 1'b1;
                state_nx = S_STOP;
            end
            S_STOP: if (tick) begin
                cnt_ld = 1'b1;
                if (last_stop) state_nx = rxs ? S_IDLE : S_WAIT_HI;
            end
            S_WAIT_HI: if (rxs) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Frame datapath: shift register, bit/stop counters and error accumulation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh    <= '0;
            bitn  <= '0;
            stopn <= 1'b0;
            pbit  <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            brk   <= 1'b0;
        end else if (tick) begin
            case (state)
                S_START: begin
                    bitn  <= '0;
                    stopn <= 1'b0;
                    pbit  <= 1'b0;
                    perr  <= 1'b0;
                    ferr  <= 1'b0;
                    brk   <= 1'b0;
                end
                S_DATA: begin
                    sh   <= {rxs, sh[DATA_BITS-1:1]};
                    bitn <= bitn + 1'b1;
                end
                S_PARITY: begin
                    pbit <= rxs;
                    perr <= ((^sh) ^ rxs) != ODD;
                end
                S_STOP: begin
                    stopn <= stopn + 1'b1;
                    ferr  <= ferr_w;
                    brk   <= brk_w;
                end
                default: ;
            endcase
        end
    end

    // Output buffer: load on delivery if free or draining, otherwise flag overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (deliver && (!o_valid || i_ready)) begin
                o_valid      <= 1'b1;
                o_data       <= sh;
                o_parity_err <= perr;
                o_frame_err  <= ferr_w;
                o_break      <= brk_w;
            end else begin
                if (deliver)            o_overrun <= 1'b1;
                if (o_valid && i_ready) o_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_cfg.sv
// tb_serial_rx_cfg: three receivers (8N1, 8E1, 7O2) at DIV=4 driven by a
// bit-banged transmitter; expected words go into per-instance queues and
// negedge monitors pop and compare on every accepted word.
module tb_serial_rx_cfg;
    localparam int DIV = 4;

    typedef struct packed {
        logic [8:0] d;
        logic       pe, fe, bk;
    } exp_t;

    logic       clk = 0, rst_n = 0;
    logic [2:0] rx  = '1, rdy = '1;
    logic [2:0] v, pe, fe, bk, ov;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    exp_t       q0[$], q1[$], q2[$];
    int         n_vec = 0, n_err = 0;
    int         ov_cnt[3] = '{0, 0, 0};
    int         lat;

    always #5 clk = ~clk;

    serial_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[0]), .o_valid(v[0]), .i_ready(rdy[0]),
        .o_data(d0), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(bk[0]), .o_overrun(ov[0]));
    serial_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[1]), .o_valid(v[1]), .i_ready(rdy[1]),
        .o_data(d1), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(bk[1]), .o_overrun(ov[1]));
    serial_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[2]), .o_valid(v[2]), .i_ready(rdy[2]),
        .o_data(d2), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(bk[2]), .o_overrun(ov[2]));

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Pop the next expected word for an instance and compare with what it presented.
    task automatic chk(input int id, input exp_t got);
        exp_t e;
        bit   have;
        e = '0;
        have = 0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL word%0d unexpected got=%h", id, got);
        end else if (got !== e) begin
            n_err++;
            $display("FAIL word%0d got={d,pe,fe,bk}=%h exp=%h", id, got, e);
        end
    endtask

    // Monitors: compare on each accepted word; count overrun-high cycles.
    always @(negedge clk) begin
        if (rst_n && v[0] && rdy[0]) chk(0, {1'b0, d0, pe[0], fe[0], bk[0]});
        if (rst_n && v[1] && rdy[1]) chk(1, {1'b0, d1, pe[1], fe[1], bk[1]});
        if (rst_n && v[2] && rdy[2]) chk(2, {2'b0, d2, pe[2], fe[2], bk[2]});
        for (int i = 0; i < 3; i++) if (ov[i]) ov_cnt[i]++;
    end

    // Bit-banged transmitter: every bit is held for DIV clocks, changed 1 time unit after an edge.
    task automatic send(input int ln, input logic [8:0] d, input int nb, input bit par,
                        input logic pb, input int ns);
        @(posedge clk); #1;
        rx[ln] = 1'b0;
        repeat (DIV) @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            rx[ln] = d[i];
            repeat (DIV) @(posedge clk); #1;
        end
        if (par) begin
            rx[ln] = pb;
            repeat (DIV) @(posedge clk); #1;
        end
        for (int i = 0; i < ns; i++) begin
            rx[ln] = 1'b1;
            repeat (DIV) @(posedge clk); #1;
        end
    endtask

    task automatic gap();
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask

    initial begin
        #15;
        check("reset_8n1", {v[0], d0, pe[0], fe[0], bk[0], ov[0]}, 0);
        check("reset_8e1", {v[1], d1, pe[1], fe[1], bk[1], ov[1]}, 0);
        check("reset_7o2", {v[2], d2, pe[2], fe[2], bk[2], ov[2]}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        gap();

        // 8N1 'K' with latency measurement: 2 + 2 + 9*4 + 1 = 41 clocks
        push(0, '{9'h04B, 1'b0, 1'b0, 1'b0});
        fork
            send(0, 9'h04B, 8, 0, 1'b0, 1);
            begin
                @(posedge clk);
                lat = 0;
                while (lat < 200) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (v[0]) break;
                end
            end
        join
        check("latency_8n1", lat, 41);
        gap();

        // 8E1: 0x4B has four ones -> correct even parity bit is 0
        push(1, '{9'h04B, 1'b1, 1'b0, 1'b0});
        send(1, 9'h04B, 8, 1, 1'b1, 1);
        gap();
        push(1, '{9'h04B, 1'b0, 1'b0, 1'b0});
        send(1, 9'h04B, 8, 1, 1'b0, 1);
        gap();

        // One-clock glitch must be rejected, next frame intact
        @(posedge clk); #1 rx[0] = 1'b0;
        @(posedge clk); #1 rx[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        push(0, '{9'h03C, 1'b0, 1'b0, 1'b0});
        send(0, 9'h03C, 8, 0, 1'b0, 1);
        gap();

        // Break: line low 20 bit times -> one word 0x00 with frame+break, then 0x55
        push(0, '{9'h000, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1 rx[0] = 1'b0;
        repeat (20 * DIV) @(posedge clk);
        #1 rx[0] = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
        push(0, '{9'h055, 1'b0, 1'b0, 1'b0});
        send(0, 9'h055, 8, 0, 1'b0, 1);
        gap();

        // Overrun: hold ready low, second word dropped
        rdy[0] = 1'b0;
        push(0, '{9'h041, 1'b0, 1'b0, 1'b0});
        send(0, 9'h041, 8, 0, 1'b0, 1);
        gap();
        send(0, 9'h042, 8, 0, 1'b0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("overrun_pulse_cycles", ov_cnt[0], 1);
        check("held_valid", v[0], 1);
        check("held_data", d0, 8'h41);
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        check("valid_drop_after_ready", v[0], 0);
        gap();

        // Reset in the middle of a 7O2 data bit, then 0x5A (four ones -> odd parity bit 1)
        @(posedge clk); #1 rx[2] = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 rx[2] = 1'b1;
        check("midreset_valid", v[2], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gap();
        push(2, '{9'h05A, 1'b0, 1'b0, 1'b0});
        send(2, 9'h05A, 7, 1, 1'b1, 2);
        repeat (20) @(posedge clk);
        #1;

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        check("overrun_8e1", ov_cnt[1], 0);
        check("overrun_7o2", ov_cnt[2], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1);
    end
endmodule
